// File: rtl/router_pkg.sv
// Shared constants for the router slice: default channel count, timeout,
// soft-reset pulse width, the per-channel timer state encodings and a helper
// that derives the destination-address width from the channel count.
// Also consumed by router_top.
package router_pkg;

  localparam int ROUTER_NUM_CH_DEF   = 3;
  localparam int ROUTER_TIMEOUT_DEF  = 30;
  localparam int ROUTER_SRST_LEN_DEF = 1;

  localparam logic [1:0] TMR_IDLE  = 2'd0;
  localparam logic [1:0] TMR_COUNT = 2'd1;
  localparam logic [1:0] TMR_PULSE = 2'd2;

  // Address width is $clog2(NUM_CH) but never narrower than one bit.
  function automatic int router_aw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/router_sync_param_if.sv
// Bus between the router FSM/register stage (master) and the synchroniser
// (slave). Optional macro ROUTER_SYNC_TO_STATUS_EN adds the sticky timeout
// status output and its per-channel clear input.
interface router_sync_param_if
  import router_pkg::*;
#(
  parameter int NUM_CH = ROUTER_NUM_CH_DEF
) ();

  localparam int AW = router_aw(NUM_CH);

  logic              detect_add;
  logic [AW-1:0]     data_in;
  logic              write_en_reg;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] re;
  logic [NUM_CH-1:0] valid;
  logic [NUM_CH-1:0] write_en;
  logic              fifo_full;
  logic              addr_err;
  logic [NUM_CH-1:0] sft_rst;
`ifdef ROUTER_SYNC_TO_STATUS_EN
  logic [NUM_CH-1:0] to_clr;
  logic [NUM_CH-1:0] to_status;
`endif

  modport master (
    output detect_add, data_in, write_en_reg, empty, full, re,
`ifdef ROUTER_SYNC_TO_STATUS_EN
    output to_clr,
    input  to_status,
`endif
    input  valid, write_en, fifo_full, addr_err, sft_rst
  );

  modport slave (
    input  detect_add, data_in, write_en_reg, empty, full, re,
`ifdef ROUTER_SYNC_TO_STATUS_EN
    input  to_clr,
    output to_status,
`endif
    output valid, write_en, fifo_full, addr_err, sft_rst
  );

endinterface

// File: rtl/router_sync_timer.sv
// One channel's unread-data watchdog. Counts consecutive valid && !re edges;
// the TIMEOUT-th such edge starts a soft-reset pulse of SRST_LEN cycles,
// after which the channel returns to IDLE and starts a fresh window.
module router_sync_timer
  import router_pkg::*;
#(
  parameter int TIMEOUT  = ROUTER_TIMEOUT_DEF,
  parameter int SRST_LEN = ROUTER_SRST_LEN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic valid,
  input  logic re,
  output logic sft_rst
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int PW = $clog2(SRST_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [PW-1:0] PLS_LAST = PW'(SRST_LEN);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pls_q, pls_d;

  // Next-state logic: the edge that would take cnt to TIMEOUT enters PULSE instead.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pls_d   = pls_q;
    case (state_q)
      TMR_IDLE: begin
        cnt_d = '0;
        pls_d = '0;
        if (valid && !re) begin
          state_d = TMR_COUNT;
          cnt_d   = CW'(1);
        end
      end
      TMR_COUNT: begin
        if (!valid || re) begin
          state_d = TMR_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = TMR_PULSE;
          cnt_d   = '0;
          pls_d   = PW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TMR_PULSE: begin
        if (pls_q == PLS_LAST) begin
          state_d = TMR_IDLE;
          pls_d   = '0;
        end else begin
          pls_d = pls_q + PW'(1);
        end
      end
      default: begin
        state_d = TMR_IDLE;
        cnt_d   = '0;
        pls_d   = '0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= TMR_IDLE;
      cnt_q   <= '0;
      pls_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pls_q   <= pls_d;
    end
  end

  assign sft_rst = (state_q == TMR_PULSE);

endmodule

// File: rtl/router_sync_param.sv
// Parametrised router synchroniser: latches the destination address, steers
// the write enable to one FIFO, muxes back its full flag, reports bad
// addresses and soft-resets channels left unread for TIMEOUT cycles.
// Optional macro ROUTER_SYNC_TO_STATUS_EN adds sticky per-channel timeout status.
module router_sync_param
  import router_pkg::*;
#(
  parameter int NUM_CH   = ROUTER_NUM_CH_DEF,
  parameter int TIMEOUT  = ROUTER_TIMEOUT_DEF,
  parameter int SRST_LEN = ROUTER_SRST_LEN_DEF,
  parameter int AW       = router_aw(NUM_CH)
) (
  input  logic                clk,
  input  logic                rst,
  router_sync_param_if.slave  bus
);

  localparam logic [AW:0] NUM_CH_W = NUM_CH[AW:0];

  logic [AW-1:0]     addr_q, addr_d;
  logic [NUM_CH-1:0] valid_w;
  logic [NUM_CH-1:0] sft_w;
  logic [NUM_CH-1:0] write_en_w;
  logic              fifo_full_w;

  // Capture a new destination address only when the FSM flags it.
  always_comb begin
    addr_d = addr_q;
    if (bus.detect_add) begin
      addr_d = bus.data_in;
    end
  end

  // Address register; steering always uses the previously latched value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  // Decode the latched address; an out-of-range address matches no channel.
  always_comb begin
    write_en_w  = '0;
    fifo_full_w = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (addr_q == AW'(i)) begin
        write_en_w[i] = bus.write_en_reg;
        fifo_full_w   = bus.full[i];
      end
    end
  end

  assign valid_w       = ~bus.empty;
  assign bus.valid     = valid_w;
  assign bus.write_en  = write_en_w;
  assign bus.fifo_full = fifo_full_w;
  assign bus.addr_err  = ({1'b0, addr_q} >= NUM_CH_W);
  assign bus.sft_rst   = sft_w;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    router_sync_timer #(
      .TIMEOUT  (TIMEOUT),
      .SRST_LEN (SRST_LEN)
    ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .valid   (valid_w[g]),
      .re      (bus.re[g]),
      .sft_rst (sft_w[g])
    );
  end

`ifdef ROUTER_SYNC_TO_STATUS_EN
  logic [NUM_CH-1:0] sft_prev_q, sft_prev_d;
  logic [NUM_CH-1:0] to_status_q, to_status_d;
  logic [NUM_CH-1:0] sft_rise;

  // Sticky status: a rising soft reset sets it and wins over a same-cycle clear.
  always_comb begin
    sft_rise    = sft_w & ~sft_prev_q;
    sft_prev_d  = sft_w;
    to_status_d = (to_status_q & ~bus.to_clr) | sft_rise;
  end

  // Status and edge-detect registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sft_prev_q  <= '0;
      to_status_q <= '0;
    end else begin
      sft_prev_q  <= sft_prev_d;
      to_status_q <= to_status_d;
    end
  end

  assign bus.to_status = to_status_q | sft_rise;
`endif

endmodule

// File: tb/tb_router_sync_param.sv
// Directed bench for router_sync_param. Two instances: a 3-channel one with
// TIMEOUT=30/SRST_LEN=1 and a 4-channel one with TIMEOUT=6/SRST_LEN=4.
// Status checks are compiled in when ROUTER_SYNC_TO_STATUS_EN is defined.
module tb_router_sync_param;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_mis = 0;

  router_sync_param_if #(.NUM_CH(3)) if3 ();
  router_sync_param_if #(.NUM_CH(4)) if4 ();

  router_sync_param #(.NUM_CH(3), .TIMEOUT(30), .SRST_LEN(1)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (if3)
  );

  router_sync_param #(.NUM_CH(4), .TIMEOUT(6), .SRST_LEN(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count a comparison and report it if the observed value differs.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Park every input at its idle value.
  task automatic applyStimulus();
    if3.detect_add = 1'b0; if3.data_in = 2'd0; if3.write_en_reg = 1'b0;
    if3.empty = 3'b111; if3.full = 3'b000; if3.re = 3'b000;
    if4.detect_add = 1'b0; if4.data_in = 2'd0; if4.write_en_reg = 1'b0;
    if4.empty = 4'b1111; if4.full = 4'b0000; if4.re = 4'b0000;
`ifdef ROUTER_SYNC_TO_STATUS_EN
    if3.to_clr = 3'b000;
    if4.to_clr = 4'b0000;
`endif
  endtask

  initial begin
    applyStimulus();
    rst = 1'b0;
    if3.full = 3'b001;
    if4.full = 4'b0001;
    tick();
    tick();
    checkOutput("rst_sft3", 32'(if3.sft_rst), 32'h0);
    checkOutput("rst_we3", 32'(if3.write_en), 32'h0);
    checkOutput("rst_full3", 32'(if3.fifo_full), 32'h1);
    checkOutput("rst_aerr3", 32'(if3.addr_err), 32'h0);
    checkOutput("rst_full4", 32'(if4.fifo_full), 32'h1);
    checkOutput("rst_sft4", 32'(if4.sft_rst), 32'h0);
    rst = 1'b1;
    tick();

    // valid follows ~empty with no latency
    if3.empty = 3'b101;
    #1;
    checkOutput("valid3", 32'(if3.valid), 32'h2);
    if3.empty = 3'b111;
    #1;

    // steering on the 4-channel instance
    if4.full = 4'b0000;
    if4.detect_add = 1'b1; if4.data_in = 2'd2;
    tick();
    if4.detect_add = 1'b0; if4.write_en_reg = 1'b1; if4.full = 4'b0100;
    #1;
    checkOutput("steer_we2", 32'(if4.write_en), 32'h4);
    checkOutput("steer_full2", 32'(if4.fifo_full), 32'h1);
    checkOutput("steer_aerr", 32'(if4.addr_err), 32'h0);
    if4.detect_add = 1'b1; if4.data_in = 2'd3;
    #1;
    checkOutput("steer_same_cyc", 32'(if4.write_en), 32'h4);
    tick();
    if4.detect_add = 1'b0;
    #1;
    checkOutput("steer_we3", 32'(if4.write_en), 32'h8);
    checkOutput("steer_full3", 32'(if4.fifo_full), 32'h0);
    if4.write_en_reg = 1'b0;
    #1;
    checkOutput("steer_we_off", 32'(if4.write_en), 32'h0);

    // out-of-range address on the 3-channel instance
    if3.full = 3'b111;
    if3.detect_add = 1'b1; if3.data_in = 2'd3;
    tick();
    if3.detect_add = 1'b0; if3.write_en_reg = 1'b1;
    #1;
    checkOutput("bad_we", 32'(if3.write_en), 32'h0);
    checkOutput("bad_full", 32'(if3.fifo_full), 32'h0);
    checkOutput("bad_aerr", 32'(if3.addr_err), 32'h1);
    if3.write_en_reg = 1'b0; if3.detect_add = 1'b1; if3.data_in = 2'd0;
    tick();
    if3.detect_add = 1'b0; if3.full = 3'b000;
    #1;
    checkOutput("good_aerr", 32'(if3.addr_err), 32'h0);

    // timeout on channel 1, then a fresh window while still valid
    if3.empty = 3'b101;
    for (int k = 1; k <= 30; k++) begin
      tick();
      checkOutput("to_edge", 32'(if3.sft_rst), (k == 30) ? 32'h2 : 32'h0);
    end
    tick();
    checkOutput("to_pulse_end", 32'(if3.sft_rst), 32'h0);
    for (int k = 1; k <= 30; k++) begin
      tick();
      checkOutput("to_rewindow", 32'(if3.sft_rst), (k == 30) ? 32'h2 : 32'h0);
    end
    if3.empty = 3'b111;
    tick();
    tick();
    checkOutput("to_idle", 32'(if3.sft_rst), 32'h0);

    // rescue: read on the last counting cycle cancels the pulse
    if3.empty = 3'b101;
    for (int k = 1; k <= 29; k++) begin
      tick();
    end
    checkOutput("resc_pre", 32'(if3.sft_rst), 32'h0);
    if3.re = 3'b010;
    tick();
    checkOutput("resc_cancel", 32'(if3.sft_rst), 32'h0);
    if3.re = 3'b000;
    for (int k = 1; k <= 30; k++) begin
      tick();
      checkOutput("resc_restart", 32'(if3.sft_rst), (k == 30) ? 32'h2 : 32'h0);
    end
    if3.empty = 3'b111;
    tick();
    tick();

    // 4-channel: valid drop mid-count clears the count, then a 4-cycle pulse
    if4.empty = 4'b1110;
    for (int k = 1; k <= 3; k++) begin
      tick();
    end
    if4.empty = 4'b1111;
    tick();
    if4.empty = 4'b1110;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checkOutput("len4_pulse", 32'(if4.sft_rst), (k >= 6 && k <= 9) ? 32'h1 : 32'h0);
`ifdef ROUTER_SYNC_TO_STATUS_EN
      checkOutput("len4_status", 32'(if4.to_status), (k >= 6) ? 32'h1 : 32'h0);
`endif
    end
    if4.empty = 4'b1111;
`ifdef ROUTER_SYNC_TO_STATUS_EN
    if4.to_clr = 4'b0001;
    tick();
    if4.to_clr = 4'b0000;
    #1;
    checkOutput("status_clr", 32'(if4.to_status), 32'h0);
`endif
    tick();

    // reset on pulse cycle 2 drops sft_rst at the next edge
    if4.empty = 4'b1110;
    for (int k = 1; k <= 7; k++) begin
      tick();
    end
    checkOutput("rstmid_pre", 32'(if4.sft_rst), 32'h1);
    rst = 1'b0;
    tick();
    checkOutput("rstmid_drop", 32'(if4.sft_rst), 32'h0);
    rst = 1'b1;
    if4.empty = 4'b1111;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
